// File: rtl/mmio_gpio_timer.sv
// mmio_gpio_timer: memory-mapped LED register, debounced switch inputs with edge status,
// and a 32-bit compare/auto-reload timer with a level interrupt.
module mmio_gpio_timer #(
   parameter int          LED_WIDTH       = 4,
   parameter int          SW_WIDTH        = 4,
   parameter logic [31:0] BASE_ADDR       = 32'hFFFF_FF00,
   parameter int          SYNC_STAGES     = 2,
   parameter int          DEBOUNCE_CYCLES = 16
) (
   input  logic                 clk,
   input  logic                 n_reset,
   input  logic                 memwrite,
   input  logic [31:0]          addr,
   input  logic [31:0]          wd,
   output logic [31:0]          rd,
   output logic                 sel,
   output logic [LED_WIDTH-1:0] led,
   input  logic [SW_WIDTH-1:0]  sw,
   output logic                 irq
);
   localparam int CW = DEBOUNCE_CYCLES > 1 ? $clog2(DEBOUNCE_CYCLES) : 1;
   logic [SW_WIDTH-1:0] sy [SYNC_STAGES];
   logic [SW_WIDTH-1:0] stable, edges, flip;
   logic [31:0]         timer, cmp;
   logic [3:0]          ctrl;
   logic                match_f, match, wr;
   logic [2:0]          off;
   logic                unused_bits;
   assign sel         = addr[31:5] == BASE_ADDR[31:5];
   assign off         = addr[4:2];
   assign wr          = memwrite & sel;
   assign match       = ctrl[0] && timer == cmp;
   assign irq         = (match_f & ctrl[2]) | (|edges & ctrl[3]);
   assign unused_bits = &{1'b0, addr[1:0], wd};
   always_ff @(posedge clk or negedge n_reset)
      if (!n_reset)
         for (int i = 0; i < SYNC_STAGES; i++) sy[i] <= '0;
      else begin
         sy[0] <= sw;
         for (int i = 1; i < SYNC_STAGES; i++) sy[i] <= sy[i-1];
      end
   // flip marks a channel whose new level has persisted long enough to be accepted this edge
   for (genvar g = 0; g < SW_WIDTH; g++) begin : gen_db
      logic [CW-1:0] cnt;
      logic          diff;
      assign diff    = sy[SYNC_STAGES-1][g] != stable[g];
      assign flip[g] = diff && cnt == CW'(DEBOUNCE_CYCLES - 1);
      always_ff @(posedge clk or negedge n_reset)
         if (!n_reset) cnt <= '0;
         else cnt <= (!diff || flip[g]) ? '0 : cnt + 1'b1;
   end
   always_ff @(posedge clk or negedge n_reset)
      if (!n_reset) begin
         led     <= '0;
         stable  <= '0;
         edges   <= '0;
         timer   <= '0;
         cmp     <= '0;
         ctrl    <= '0;
         match_f <= 1'b0;
      end else begin
         if (wr && off == 3'd0) led <= wd[LED_WIDTH-1:0];
         if (wr && off == 3'd4) cmp <= wd;
         if (wr && off == 3'd5) ctrl <= wd[3:0];
         stable  <= stable ^ flip;
         edges   <= (edges & ~((wr && off == 3'd2) ? wd[SW_WIDTH-1:0] : '0)) | (flip & ~stable);
         timer   <= (wr && off == 3'd3) ? wd : !ctrl[0] ? timer : (match && ctrl[1]) ? '0 : timer + 32'd1;
         match_f <= match | (match_f & ~(wr && off == 3'd5 && wd[8]));
      end
   always_comb begin
      rd = '0;
      if (sel)
         case (off)
            3'd0:    rd = 32'(led);
            3'd1:    rd = 32'(stable);
            3'd2:    rd = 32'(edges);
            3'd3:    rd = timer;
            3'd4:    rd = cmp;
            3'd5:    rd = {23'd0, match_f, 4'd0, ctrl};
            default: rd = '0;
         endcase
   end
endmodule
